// File: rtl/fmap_stream_tx_if.sv
// -----------------------------------------------------------------------------
// fmap_stream_tx_if
// Bundles the frame-buffer write port, the stream control pair and the pixel
// beat stream of fmap_stream_tx.
//   master : host side (drives writes, start, hold; observes beats/status)
//   slave  : fmap_stream_tx side
// Signals:
//   wr_en, wr_addr, wr_din  pixel write into the frame buffer
//   wr_drop                 one-cycle pulse when a write is rejected
//   start, hold             stream request / issue pause
//   busy                    frame in progress
//   input_vld, input_din    pixel beat towards the pointwise conv stage
//   stream_end              pulse on the last beat of a frame
// -----------------------------------------------------------------------------
interface fmap_stream_tx_if #(
    parameter int N       = 16,
    parameter int CHANNEL = 3,
    parameter int ADDR_W  = 6
);
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [CHANNEL*N-1:0]   wr_din;
    logic                   wr_drop;
    logic                   start;
    logic                   hold;
    logic                   busy;
    logic                   input_vld;
    logic [CHANNEL*N-1:0]   input_din;
    logic                   stream_end;

    modport master (
        output wr_en, wr_addr, wr_din, start, hold,
        input  wr_drop, busy, input_vld, input_din, stream_end
    );

    modport slave (
        input  wr_en, wr_addr, wr_din, start, hold,
        output wr_drop, busy, input_vld, input_din, stream_end
    );
endinterface

// File: rtl/fmap_stream_tx.sv
// -----------------------------------------------------------------------------
// fmap_stream_tx
// Holds one SIZE x SIZE feature map (CHANNEL samples of N bits per pixel) and
// streams it, one pixel per beat in ascending address order, to the pointwise
// conv stage.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fmap_stream_tx_if.slave: write port, start/hold, beat stream,
//          busy, stream_end, wr_drop
// Writes are only accepted while idle so a frame is never modified mid-stream.
// -----------------------------------------------------------------------------
module fmap_stream_tx #(
    parameter int N       = 16,
    parameter int CHANNEL = 3,
    parameter int SIZE    = 6,
    parameter int ADDR_W  = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    fmap_stream_tx_if.slave bus
);
    localparam int DEPTH = SIZE * SIZE;
    localparam int W     = CHANNEL * N;
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] rd_addr, rd_addr_d;
    logic              issue;
    logic              last_issue;
    logic              wr_ok;

    logic [W-1:0]      mem [DEPTH];

    logic              vld_q;
    logic              end_q;
    logic              drop_q;
    logic [W-1:0]      dout_q;

    // Writes land only while idle and in range; the start cycle is still idle,
    // so a write paired with start is stored before address 0 is read.
    assign wr_ok = bus.wr_en && (state == IDLE) && ({1'b0, bus.wr_addr} < DEPTH_W);

    always_comb begin
        state_d    = state;
        rd_addr_d  = rd_addr;
        issue      = 1'b0;
        last_issue = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_d   = ISSUE;
                    rd_addr_d = '0;
                end
            end
            ISSUE: begin
                if (!bus.hold) begin
                    issue     = 1'b1;
                    rd_addr_d = rd_addr + ADDR_W'(1);
                    if (rd_addr == LAST_ADDR) begin
                        last_issue = 1'b1;
                        state_d    = DRAIN;
                    end
                end
            end
            // DRAIN is the cycle the final beat is on the output.
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rd_addr <= '0;
            vld_q   <= 1'b0;
            end_q   <= 1'b0;
            drop_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state   <= state_d;
            rd_addr <= rd_addr_d;
            vld_q   <= issue;
            end_q   <= last_issue;
            drop_q  <= bus.wr_en && !wr_ok;
            // Output word only changes on an issued read, so it holds otherwise.
            if (issue) begin
                dout_q <= mem[rd_addr];
            end
        end
    end

    // Frame buffer storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_din;
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.input_vld  = vld_q;
    assign bus.input_din  = dout_q;
    assign bus.stream_end = end_q;
    assign bus.wr_drop    = drop_q;

endmodule

// File: tb/tb_fmap_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_fmap_stream_tx
// Directed bench for fmap_stream_tx at default parameters (6x6 map, 3 x 16b).
// Inputs change just after the falling edge; outputs are sampled on the
// falling edge, where every observed beat is also recorded.
// -----------------------------------------------------------------------------
module tb_fmap_stream_tx;
    localparam int N      = 16;
    localparam int CH     = 3;
    localparam int SIZE   = 6;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = SIZE * SIZE;

    logic clk;
    logic rst_n;

    fmap_stream_tx_if #(.N(N), .CHANNEL(CH), .ADDR_W(ADDR_W)) bus ();

    fmap_stream_tx #(
        .N       (N),
        .CHANNEL (CH),
        .SIZE    (SIZE),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_n    = 0;

    logic [CH*N-1:0] bq_data [$];
    bit              bq_end  [$];
    int              bq_cyc  [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and record any beat present there.
    task automatic tick();
        @(negedge clk);
        cyc_n++;
        if (bus.input_vld) begin
            bq_data.push_back(bus.input_din);
            bq_end.push_back(bus.stream_end);
            bq_cyc.push_back(cyc_n);
        end
    endtask

    // Pixel p, channel c holds p*4+c.
    function automatic logic [CH*N-1:0] pix(input int p);
        logic [CH*N-1:0] w;
        w = '0;
        for (int c = 0; c < CH; c++) begin
            w[c*N +: N] = N'(p * 4 + c);
        end
        return w;
    endfunction

    task automatic clear_beats();
        bq_data.delete();
        bq_end.delete();
        bq_cyc.delete();
    endtask

    // Run one frame and check it.
    //   hold_at     : raise hold for 3 cycles once this many beats are seen (-1 off)
    //   restart_at  : pulse start once this many beats are seen (-1 off)
    //   restart_end : pulse start in the stream_end cycle
    //   wr_mid      : attempt a write after 3 beats (must be dropped)
    //   hold_start  : hold high together with start in IDLE (ignored)
    //   wr_start    : write address 0 with exp0 together with start
    task automatic stream(input string tag, input int hold_at, input int restart_at,
                          input bit restart_end, input bit wr_mid, input bit hold_start,
                          input bit wr_start, input logic [CH*N-1:0] exp0);
        int budget;
        int hold_left;
        int t_cyc;
        int fall_cyc;
        int n_end;
        int end_idx;
        bit hold_done;
        bit rs_done;
        bit wr_done;
        bit drop_exp;
        logic [CH*N-1:0] exp_w;

        clear_beats();
        bus.start = 1'b1;
        bus.hold  = hold_start;
        if (wr_start) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = '0;
            bus.wr_din  = exp0;
        end
        tick();
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        bus.wr_en = 1'b0;
        t_cyc = cyc_n;
        check({tag, "_busy_rise"}, bus.busy, 1);
        check({tag, "_no_early_vld"}, bus.input_vld, 0);

        budget    = 0;
        hold_left = 0;
        hold_done = 0;
        rs_done   = 0;
        wr_done   = 0;
        drop_exp  = 0;
        while (bus.busy && budget < 200) begin
            if (drop_exp) check({tag, "_drop_busy"}, bus.wr_drop, 1);
            drop_exp  = 0;
            bus.hold  = 1'b0;
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            if (hold_left > 0) begin
                bus.hold = 1'b1;
                hold_left--;
            end else if (!hold_done && bq_data.size() == hold_at) begin
                bus.hold  = 1'b1;
                hold_left = 2;
                hold_done = 1;
            end
            if (!rs_done && bq_data.size() == restart_at) begin
                bus.start = 1'b1;
                rs_done   = 1;
            end
            if (restart_end && bus.stream_end) bus.start = 1'b1;
            if (wr_mid && !wr_done && bq_data.size() == 3) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 6'd7;
                bus.wr_din  = '1;
                wr_done     = 1;
                drop_exp    = 1;
            end
            tick();
            budget++;
        end
        bus.hold  = 1'b0;
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        check({tag, "_done_in_budget"}, (budget < 200), 1);
        fall_cyc = cyc_n;

        // A start in the stream_end cycle must not relaunch the frame.
        tick();
        check({tag, "_stays_idle"}, bus.busy, 0);
        check({tag, "_no_extra_vld"}, bus.input_vld, 0);

        check({tag, "_count"}, bq_data.size(), DEPTH);
        n_end   = 0;
        end_idx = -1;
        for (int k = 0; k < bq_data.size() && k < DEPTH; k++) begin
            exp_w = (k == 0) ? exp0 : pix(k);
            check($sformatf("%s_beat%0d", tag, k), bq_data[k], exp_w);
        end
        for (int k = 0; k < bq_end.size(); k++) begin
            if (bq_end[k]) begin
                n_end++;
                if (end_idx < 0) end_idx = k;
            end
        end
        check({tag, "_end_count"}, n_end, 1);
        check({tag, "_end_idx"}, end_idx, DEPTH - 1);
        if (bq_data.size() >= DEPTH) begin
            check({tag, "_latency"}, bq_cyc[0] - t_cyc, 1);
            check({tag, "_span"}, bq_cyc[DEPTH-1] - bq_cyc[0],
                  (hold_at >= 0) ? DEPTH - 1 + 3 : DEPTH - 1);
            check({tag, "_busy_fall"}, fall_cyc - bq_cyc[DEPTH-1], 1);
            if (hold_at > 0) begin
                check({tag, "_hold_gap"}, bq_cyc[hold_at] - bq_cyc[hold_at-1], 4);
            end
        end
    endtask

    int n_before;
    int budget;

    initial begin
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_din  = '0;
        bus.start   = 1'b0;
        bus.hold    = 1'b0;
        repeat (3) tick();
        check("rst_busy", bus.busy, 0);
        check("rst_vld", bus.input_vld, 0);
        check("rst_end", bus.stream_end, 0);
        check("rst_drop", bus.wr_drop, 0);
        check("rst_din", bus.input_din, 0);
        rst_n = 1'b1;
        tick();

        // Load the frame.
        for (int p = 0; p < DEPTH; p++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = ADDR_W'(p);
            bus.wr_din  = pix(p);
            tick();
            if (p == 0) check("load_no_drop", bus.wr_drop, 0);
        end
        bus.wr_en = 1'b0;
        tick();

        stream("f1", -1, -1, 0, 0, 0, 0, pix(0));
        stream("hold", 6, -1, 0, 0, 0, 0, pix(0));
        stream("restart", -1, 10, 1, 0, 0, 0, pix(0));

        // Out-of-range write in IDLE.
        bus.wr_en   = 1'b1;
        bus.wr_addr = 6'd40;
        bus.wr_din  = '1;
        tick();
        bus.wr_en = 1'b0;
        check("drop_oob", bus.wr_drop, 1);
        tick();
        check("drop_pulse_once", bus.wr_drop, 0);

        stream("f2", -1, -1, 0, 1, 1, 0, pix(0));
        stream("wrstart", -1, -1, 0, 0, 0, 1, 48'h1234_5678_9abc);

        // Restore pixel 0.
        bus.wr_en   = 1'b1;
        bus.wr_addr = '0;
        bus.wr_din  = pix(0);
        tick();
        bus.wr_en = 1'b0;
        tick();

        // Reset in the middle of a frame.
        clear_beats();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        budget = 0;
        while (bq_data.size() < 21 && budget < 100) begin
            tick();
            budget++;
        end
        check("midrst_reach_beat20", bq_data.size(), 21);
        check("midrst_beat20", bq_data[bq_data.size()-1], pix(20));
        #1 rst_n = 1'b0;
        #1;
        check("midrst_vld", bus.input_vld, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_end", bus.stream_end, 0);
        check("midrst_din", bus.input_din, 0);
        n_before = bq_data.size();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("midrst_no_beats", bq_data.size(), n_before);
        check("midrst_idle", bus.busy, 0);

        stream("after_rst", -1, -1, 0, 0, 0, 0, pix(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
